// File: rtl/io_interrupt_ctrl_if.sv
// CPU-side and device-side signal bundle for io_interrupt_ctrl.
// The controller connects through the slave modport; CPU/device models use master.
interface io_interrupt_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int NCH    = 2,
    parameter int CH_W   = 1
);
    logic [2:0]            cpu_op;
    logic [CH_W-1:0]       cpu_ch;
    logic [DATA_W-1:0]     cpu_wdata;
    logic [DATA_W-1:0]     cpu_rdata;
    logic                  cpu_skip;
    logic                  cpu_t_end;
    logic                  cpu_irq_ack;
    logic                  irq;
    logic [CH_W-1:0]       irq_ch;
    logic                  ien;
    logic [NCH*DATA_W-1:0] dev_in_data;
    logic [NCH-1:0]        dev_in_valid;
    logic [NCH-1:0]        dev_in_ready;
    logic [NCH*DATA_W-1:0] dev_out_data;
    logic [NCH-1:0]        dev_out_valid;
    logic [NCH-1:0]        dev_out_ready;

    modport slave (
        input  cpu_op, cpu_ch, cpu_wdata, cpu_t_end, cpu_irq_ack,
        input  dev_in_data, dev_in_valid, dev_out_ready,
        output cpu_rdata, cpu_skip, irq, irq_ch, ien,
        output dev_in_ready, dev_out_data, dev_out_valid
    );

    modport master (
        output cpu_op, cpu_ch, cpu_wdata, cpu_t_end, cpu_irq_ack,
        output dev_in_data, dev_in_valid, dev_out_ready,
        input  cpu_rdata, cpu_skip, irq, irq_ch, ien,
        input  dev_in_ready, dev_out_data, dev_out_valid
    );
endinterface

// File: rtl/io_interrupt_ctrl.sv
// Multi-channel INPR/OUTR + FGI/FGO + IEN/R I/O and interrupt controller.
// Define IRQ_MASK_EN to add a per-channel interrupt mask register loaded by MSK.
module io_interrupt_ctrl #(
    parameter int DATA_W = 8,
    parameter int NCH    = 2,
    parameter int CH_W   = 1
) (
    input  logic                 clk,
    input  logic                 CLR_GLOBAL,
    io_interrupt_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        OP_NOP = 3'd0, OP_INP = 3'd1, OP_OUT = 3'd2, OP_SKI = 3'd3,
        OP_SKO = 3'd4, OP_ION = 3'd5, OP_IOF = 3'd6, OP_MSK = 3'd7
    } op_e;

    typedef enum logic {R_IDLE = 1'b0, R_PEND = 1'b1} r_state_e;

    logic [DATA_W-1:0] inpr_q [NCH];
    logic [DATA_W-1:0] inpr_d [NCH];
    logic [DATA_W-1:0] outr_q [NCH];
    logic [DATA_W-1:0] outr_d [NCH];
    logic [NCH-1:0]    fgi_q, fgi_d, fgo_q, fgo_d;
    logic              ien_q, ien_d;
    r_state_e          state_q, state_d;
    logic [CH_W-1:0]   irq_ch_q, irq_ch_d;
    logic [NCH-1:0]    mask;
    logic [NCH-1:0]    pend;
    logic [CH_W-1:0]   first_idx;
    logic              first_found;
    op_e               op;
    logic              ch_ok;

    assign op    = op_e'(bus.cpu_op);
    assign ch_ok = int'(bus.cpu_ch) < NCH;

`ifdef IRQ_MASK_EN
    logic [NCH-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (op == OP_MSK) mask_d = bus.cpu_wdata[NCH-1:0];
    end

    always_ff @(posedge clk or posedge CLR_GLOBAL) begin
        if (CLR_GLOBAL) mask_q <= '1;
        else            mask_q <= mask_d;
    end

    assign mask = mask_q;
`else
    assign mask = '1;
`endif

    assign pend = (fgi_q | fgo_q) & mask;

    always_comb begin
        first_idx   = '0;
        first_found = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (pend[i] && !first_found) begin
                first_idx   = CH_W'(i);
                first_found = 1'b1;
            end
        end
    end

    // Device-side and CPU-side flag updates never collide: each side only acts
    // on the flag value the other side leaves alone.
    always_comb begin
        inpr_d = inpr_q;
        outr_d = outr_q;
        fgi_d  = fgi_q;
        fgo_d  = fgo_q;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.dev_in_valid[i] && !fgi_q[i]) begin
                inpr_d[i] = bus.dev_in_data[i*DATA_W +: DATA_W];
                fgi_d[i]  = 1'b1;
            end
            if (bus.dev_out_ready[i] && !fgo_q[i]) fgo_d[i] = 1'b1;
        end
        if (ch_ok) begin
            if (op == OP_INP && fgi_q[bus.cpu_ch]) fgi_d[bus.cpu_ch] = 1'b0;
            if (op == OP_OUT && fgo_q[bus.cpu_ch]) begin
                outr_d[bus.cpu_ch] = bus.cpu_wdata;
                fgo_d[bus.cpu_ch]  = 1'b0;
            end
        end
    end

    always_comb begin
        ien_d    = ien_q;
        state_d  = state_q;
        irq_ch_d = irq_ch_q;
        if (op == OP_ION) ien_d = 1'b1;
        if (op == OP_IOF) ien_d = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (bus.cpu_t_end && ien_q && first_found && !bus.cpu_irq_ack) begin
                    state_d  = R_PEND;
                    irq_ch_d = first_idx;
                end
            end
            R_PEND:  state_d = R_PEND;
            default: state_d = R_IDLE;
        endcase
        if (bus.cpu_irq_ack) begin
            state_d = R_IDLE;
            ien_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge CLR_GLOBAL) begin
        if (CLR_GLOBAL) begin
            inpr_q   <= '{default: '0};
            outr_q   <= '{default: '0};
            fgi_q    <= '0;
            fgo_q    <= '1;
            ien_q    <= 1'b0;
            state_q  <= R_IDLE;
            irq_ch_q <= '0;
        end else begin
            inpr_q   <= inpr_d;
            outr_q   <= outr_d;
            fgi_q    <= fgi_d;
            fgo_q    <= fgo_d;
            ien_q    <= ien_d;
            state_q  <= state_d;
            irq_ch_q <= irq_ch_d;
        end
    end

    always_comb begin
        bus.cpu_rdata = '0;
        bus.cpu_skip  = 1'b0;
        if (ch_ok) begin
            bus.cpu_rdata = inpr_q[bus.cpu_ch];
            if (op == OP_SKI) bus.cpu_skip = fgi_q[bus.cpu_ch];
            if (op == OP_SKO) bus.cpu_skip = fgo_q[bus.cpu_ch];
        end
    end

    always_comb begin
        bus.dev_out_data = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            bus.dev_out_data[i*DATA_W +: DATA_W] = outr_q[i];
        end
    end

    assign bus.irq           = (state_q == R_PEND);
    assign bus.irq_ch        = irq_ch_q;
    assign bus.ien           = ien_q;
    assign bus.dev_in_ready  = ~fgi_q;
    assign bus.dev_out_valid = ~fgo_q;
endmodule

// File: tb/tb_io_interrupt_ctrl.sv
// Directed and randomized bench for io_interrupt_ctrl against a per-cycle flag model.
module tb_io_interrupt_ctrl;
    localparam int DW  = 8;
    localparam int NCH = 2;
    localparam int CHW = 1;

    logic clk;
    logic CLR_GLOBAL;
    int   checks;
    int   failures;

    io_interrupt_ctrl_if #(.DATA_W(DW), .NCH(NCH), .CH_W(CHW)) bus_if ();

    io_interrupt_ctrl #(.DATA_W(DW), .NCH(NCH), .CH_W(CHW)) dut (
        .clk        (clk),
        .CLR_GLOBAL (CLR_GLOBAL),
        .bus        (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [DW-1:0]  m_inpr [NCH];
    logic [DW-1:0]  m_outr [NCH];
    logic [NCH-1:0] m_fgi, m_fgo, m_mask;
    logic           m_ien, m_r;
    int             m_rch;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_inpr[i] = '0;
            m_outr[i] = '0;
        end
        m_fgi  = '0;
        m_fgo  = '1;
        m_mask = '1;
        m_ien  = 1'b0;
        m_r    = 1'b0;
        m_rch  = 0;
    endtask

    function automatic int lowest(input logic [NCH-1:0] p);
        for (int i = 0; i < NCH; i++) if (p[i]) return i;
        return 0;
    endfunction

    task automatic check_state();
        logic [NCH-1:0]    e_rdy, e_val;
        logic [NCH*DW-1:0] e_od;
        e_rdy = ~m_fgi;
        e_val = ~m_fgo;
        for (int i = 0; i < NCH; i++) e_od[i*DW +: DW] = m_outr[i];
        chk("irq", bus_if.irq, m_r);
        chk("irq_ch", bus_if.irq_ch, m_rch);
        chk("ien", bus_if.ien, m_ien);
        chk("dev_in_ready", bus_if.dev_in_ready, e_rdy);
        chk("dev_out_valid", bus_if.dev_out_valid, e_val);
        chk("dev_out_data", bus_if.dev_out_data, e_od);
    endtask

    task automatic do_reset();
        CLR_GLOBAL = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1 CLR_GLOBAL = 1'b0;
        check_state();
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check state.
    task automatic step(input logic [2:0] op, input int ch, input logic [DW-1:0] wd,
                        input logic te, input logic ack, input logic [NCH-1:0] iv,
                        input logic [NCH*DW-1:0] idat, input logic [NCH-1:0] ordy);
        logic [DW-1:0]  n_inpr [NCH];
        logic [DW-1:0]  n_outr [NCH];
        logic [NCH-1:0] n_fgi, n_fgo, pend;
        logic           e_skip;
        bus_if.cpu_op        = op;
        bus_if.cpu_ch        = CHW'(ch);
        bus_if.cpu_wdata     = wd;
        bus_if.cpu_t_end     = te;
        bus_if.cpu_irq_ack   = ack;
        bus_if.dev_in_valid  = iv;
        bus_if.dev_in_data   = idat;
        bus_if.dev_out_ready = ordy;
        #3;
        e_skip = (op == 3'd3) ? m_fgi[ch] : (op == 3'd4) ? m_fgo[ch] : 1'b0;
        chk("cpu_rdata", bus_if.cpu_rdata, m_inpr[ch]);
        chk("cpu_skip", bus_if.cpu_skip, e_skip);

        pend  = (m_fgi | m_fgo) & m_mask;
        n_inpr = m_inpr;
        n_outr = m_outr;
        n_fgi  = m_fgi;
        n_fgo  = m_fgo;
        for (int i = 0; i < NCH; i++) begin
            if (iv[i] && !m_fgi[i]) begin
                n_inpr[i] = idat[i*DW +: DW];
                n_fgi[i]  = 1'b1;
            end
            if (ordy[i] && !m_fgo[i]) n_fgo[i] = 1'b1;
        end
        case (op)
            3'd1: if (m_fgi[ch]) n_fgi[ch] = 1'b0;
            3'd2: if (m_fgo[ch]) begin
                n_outr[ch] = wd;
                n_fgo[ch]  = 1'b0;
            end
            3'd5: m_ien = 1'b1;
            3'd6: m_ien = 1'b0;
`ifdef IRQ_MASK_EN
            3'd7: m_mask = wd[NCH-1:0];
`endif
            default: ;
        endcase
        if (ack) begin
            m_ien = 1'b0;
            m_r   = 1'b0;
        end else if (!m_r && te && bus_if.ien && pend != '0) begin
            m_r   = 1'b1;
            m_rch = lowest(pend);
        end
        m_inpr = n_inpr;
        m_outr = n_outr;
        m_fgi  = n_fgi;
        m_fgo  = n_fgo;
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic nop();
        step(3'd0, 0, '0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus_if.cpu_op = '0; bus_if.cpu_ch = '0; bus_if.cpu_wdata = '0;
        bus_if.cpu_t_end = 1'b0; bus_if.cpu_irq_ack = 1'b0;
        bus_if.dev_in_valid = '0; bus_if.dev_in_data = '0; bus_if.dev_out_ready = '0;
        #1;
        do_reset();
        chk("rst_out_valid", bus_if.dev_out_valid, 0);
        chk("rst_in_ready", bus_if.dev_in_ready, 3);

        // Input path on channel 1.
        step(3'd0, 0, '0, 1'b0, 1'b0, 2'b10, 16'hFF00, '0);
        chk("in_ready_ch1_low", bus_if.dev_in_ready[1], 0);
        step(3'd3, 1, '0, 1'b0, 1'b0, '0, '0, '0);
        step(3'd1, 1, '0, 1'b0, 1'b0, '0, '0, '0);
        chk("in_ready_after_inp", bus_if.dev_in_ready, 3);
        step(3'd1, 1, '0, 1'b0, 1'b0, '0, '0, '0);

        // Output path on channel 0, second OUT dropped.
        step(3'd2, 0, 8'h41, 1'b0, 1'b0, '0, '0, '0);
        chk("out_data_41", bus_if.dev_out_data[7:0], 8'h41);
        step(3'd2, 0, 8'h42, 1'b0, 1'b0, '0, '0, '0);
        chk("out_data_held", bus_if.dev_out_data[7:0], 8'h41);
        step(3'd4, 0, '0, 1'b0, 1'b0, '0, '0, 2'b01);
        chk("out_valid_dropped", bus_if.dev_out_valid[0], 0);

        // Priority: both input flags set together, lowest channel wins.
        step(3'd5, 0, '0, 1'b0, 1'b0, '0, '0, '0);
        step(3'd0, 0, '0, 1'b0, 1'b0, 2'b11, 16'h3A5C, '0);
        step(3'd0, 0, '0, 1'b1, 1'b0, '0, '0, '0);
        chk("prio_irq", bus_if.irq, 1);
        chk("prio_irq_ch", bus_if.irq_ch, 0);
        step(3'd0, 1, '0, 1'b1, 1'b0, '0, '0, '0);
        step(3'd0, 0, '0, 1'b0, 1'b1, '0, '0, '0);
        chk("ack_irq", bus_if.irq, 0);
        chk("ack_ien", bus_if.ien, 0);

        // Gating: no request while IEN is clear; ack beats a same-cycle ION.
        step(3'd0, 0, '0, 1'b1, 1'b0, '0, '0, '0);
        chk("gated_irq", bus_if.irq, 0);
        step(3'd5, 0, '0, 1'b0, 1'b1, '0, '0, '0);
        chk("ion_vs_ack", bus_if.ien, 0);

        // Asynchronous reset while R is set.
        step(3'd5, 0, '0, 1'b0, 1'b0, '0, '0, '0);
        step(3'd0, 0, '0, 1'b1, 1'b0, '0, '0, '0);
        chk("pre_reset_irq", bus_if.irq, 1);
        #2 CLR_GLOBAL = 1'b1;
        #1;
        chk("async_irq", bus_if.irq, 0);
        chk("async_ien", bus_if.ien, 0);
        chk("async_in_ready", bus_if.dev_in_ready, 3);
        chk("async_out_valid", bus_if.dev_out_valid, 0);
        model_reset();
        @(posedge clk);
        #1 CLR_GLOBAL = 1'b0;
        check_state();

`ifdef IRQ_MASK_EN
        step(3'd2, 1, 8'h55, 1'b0, 1'b0, '0, '0, '0);
        step(3'd7, 0, 8'h02, 1'b0, 1'b0, '0, '0, '0);
        step(3'd5, 0, '0, 1'b0, 1'b0, '0, '0, '0);
        step(3'd0, 0, '0, 1'b0, 1'b0, 2'b01, 16'h0011, '0);
        step(3'd0, 0, '0, 1'b1, 1'b0, '0, '0, '0);
        chk("mask_blocks_ch0", bus_if.irq, 0);
        step(3'd3, 0, '0, 1'b0, 1'b0, '0, '0, '0);
        step(3'd0, 0, '0, 1'b0, 1'b0, 2'b10, 16'h2200, '0);
        step(3'd0, 0, '0, 1'b1, 1'b0, '0, '0, '0);
        chk("mask_irq_ch1", bus_if.irq, 1);
        chk("mask_irq_ch", bus_if.irq_ch, 1);
        do_reset();
`endif

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [2:0] r_op;
            logic       r_te, r_ack;
            r_op  = 3'($urandom_range(0, 7));
            r_te  = ($urandom_range(0, 3) == 0);
            r_ack = bus_if.irq && ($urandom_range(0, 2) == 0);
            step(r_op, int'($urandom_range(0, NCH - 1)), DW'($urandom), r_te, r_ack,
                 NCH'($urandom), (NCH*DW)'($urandom), NCH'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_interrupt_ctrl.md
Name: io_interrupt_ctrl

Overview:
- Parametrised multi-channel I/O and interrupt controller for the basic-computer datapath.
- Generalises the single INPR/OUTR, FGI/FGO and IEN/R scheme to NCH channels of DATA_W bits.
- Adds valid/ready device handshakes and a latched interrupt-source index.
- Sits between the CPU control unit (driven by decoded I/O instructions) and external character devices.

Parameters:
DATA_W, 8, width of each INPR/OUTR register
NCH, 2, number of I/O channels (1..8)
CH_W, 1, channel index width; must equal max(1, clog2(NCH))

Ports:
clk  in  1  system clock, all state on rising edge
CLR_GLOBAL  in  1  asynchronous active-high reset
cpu_op  in  3  0 NOP, 1 INP, 2 OUT, 3 SKI, 4 SKO, 5 ION, 6 IOF, 7 MSK
cpu_ch  in  CH_W  channel addressed by INP/OUT/SKI/SKO
cpu_wdata  in  DATA_W  AC low bits for OUT; mask bits for MSK
cpu_rdata  out  DATA_W  INPR[cpu_ch], combinational
cpu_skip  out  1  combinational skip condition for SKI/SKO
cpu_t_end  in  1  one-cycle strobe marking an instruction boundary (SC about to return to 0)
cpu_irq_ack  in  1  interrupt cycle completed (return address stored, PC loaded)
irq  out  1  R flip-flop
irq_ch  out  CH_W  channel latched when R sets
ien  out  1  interrupt enable flip-flop
dev_in_data  in  NCH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
dev_in_valid  in  NCH  device offers input byte
dev_in_ready  out  NCH  equals ~FGI[i]
dev_out_data  out  NCH*DATA_W  OUTR registers, packed as dev_in_data
dev_out_valid  out  NCH  equals ~FGO[i]
dev_out_ready  in  NCH  device consumes output byte

Behaviour:
- Reset values:
  - INPR = 0, OUTR = 0, FGI = 0, FGO = all 1, IEN = 0, R = 0, irq_ch = 0.
  - Mask = all 1 when IRQ_MASK_EN is defined.
  - All outputs are derived from these values.
- Input channel i:
  - dev_in_valid[i] & ~FGI[i] -> INPR[i] <= data and FGI[i] <= 1 on the next edge.
  - While FGI[i] = 1, valid is not accepted.
- INP:
  - cpu_rdata = INPR[cpu_ch] in the same cycle.
  - FGI[cpu_ch] <= 0 at the edge.
  - INP while FGI = 0 returns the stale INPR; no state change.
- Output channel i:
  - OUT with FGO[ch] = 1 -> OUTR[ch] <= cpu_wdata and FGO[ch] <= 0.
  - OUT with FGO[ch] = 0 is dropped; OUTR is unchanged.
  - dev_out_ready[i] & ~FGO[i] -> FGO[i] <= 1 at the edge; one-cycle handshake latency.
- Skip outputs:
  - cpu_skip = FGI[ch] during SKI, FGO[ch] during SKO, 0 for all other ops.
- ION / IOF:
  - ION sets IEN at the edge; IOF clears IEN.
  - ION and cpu_irq_ack in the same cycle -> ack wins, IEN = 0.
- Pending vector:
  - pend[i] = (FGI[i] | FGO[i]) & mask[i]; mask is all-ones without the feature.
- Interrupt request:
  - At an edge with cpu_t_end & IEN & |pend & ~R: R <= 1 and irq_ch <= lowest index i with pend[i].
  - R holds until cpu_irq_ack; ack clears R and IEN at the edge.
  - cpu_t_end while R = 1: no effect, irq_ch is held.
- Same-cycle flag events:
  - A flag set/clear in the same cycle as cpu_t_end is evaluated on pre-edge values.
  - The flag change takes effect after the edge.
- Decode rules:
  - cpu_ch >= NCH: INP/OUT/SKI/SKO are no-ops; cpu_rdata = 0, cpu_skip = 0.
  - Ops 3..7 never alter data registers.
- Asynchronous reset:
  - CLR_GLOBAL asserted mid-handshake or mid-interrupt immediately returns all state to reset values, including pending R and half-completed device transfers.

Optional Feature:
- IRQ_MASK_EN defined:
  - Adds an NCH-bit mask register, reset all 1.
  - MSK (op 7) loads mask <= cpu_wdata[NCH-1:0]; requires NCH <= DATA_W.
  - Masked channels still set flags and still answer SKI/SKO, but never raise R.
- IRQ_MASK_EN not defined:
  - No mask register; op 7 is a NOP; every channel can interrupt.

Test Plan:
- Reset check: assert CLR_GLOBAL, release -> dev_out_valid = 0, dev_in_ready = all 1, irq = 0, ien = 0.
- Input path: dev_in_valid[1] = 1 with data 0xFF on ch1 -> next edge dev_in_ready[1] = 0. SKI ch1 -> cpu_skip = 1. INP ch1 -> cpu_rdata = 0xFF, then dev_in_ready[1] = 1.
- Output path: OUT ch0 with 0x41 -> dev_out_valid[0] = 1, data = 0x41. A second OUT 0x42 before ready -> data stays 0x41. dev_out_ready[0] pulse -> valid drops next edge.
- Interrupt priority: ION, then FGI set on ch1 and ch0 in the same cycle, then cpu_t_end -> irq = 1, irq_ch = 0. cpu_irq_ack -> irq = 0, ien = 0.
- Interrupt gating: cpu_t_end with IEN = 0 and pending flags -> irq stays 0. Reset asserted while irq = 1 -> irq = 0 immediately, before the next clock edge.
- Mask (IRQ_MASK_EN build): MSK 0x02, ION, FGI on ch0 only, cpu_t_end -> irq = 0. Then FGI on ch1, cpu_t_end -> irq = 1, irq_ch = 1.
